// File: rtl/packing_buffer.sv
// packing_buffer
//
// Collects NLANES ALU lane results per input beat over NBEATS beats and
// presents them as one OUT_W-bit cipher state word. The word is packed
// either row-major, with global lane 0 in the MSBs, or transposed into
// column-major byte order for the MixColumns unit.
//
// The final beat is not stored. It is merged combinationally with the
// assembly buffer and loaded straight into the output register. This
// makes the word visible one cycle after the last beat is accepted.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   a beat can be accepted this cycle
//   in_lanes   NLANES lane results, lane 0 in the MSBs
//   mc_mode    1 = transposed (MixColumns) packing; sampled on beat 0 only
//   clear      synchronous abort of a partially assembled word
//   out_valid  packed word available
//   out_ready  consumer accepts the packed word
//   out_data   packed word
//   out_mode   packing mode of the presented word
module packing_buffer #(
    parameter int LANE_W = 32,
    parameter int NLANES = 2,
    parameter int NBEATS = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANE_W*NLANES-1:0]   in_lanes,
    input  logic                       mc_mode,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANE_W*NLANES*NBEATS-1:0] out_data,
    output logic                       out_mode
);

    localparam int BEAT_W = LANE_W * NLANES;
    localparam int OUT_W  = BEAT_W * NBEATS;
    localparam int ROWS   = NLANES * NBEATS;
    localparam int COLS   = LANE_W / 8;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBEATS - 1);

    logic [CNT_W-1:0] beat_cnt;
    logic [OUT_W-1:0] asm_buf;
    logic             mode_latched;
    logic             accept;
    logic             final_beat;
    logic             eff_mode;
    logic [OUT_W-1:0] row_word;
    logic [OUT_W-1:0] packed_word;

    // Row-major byte (r, c) sits at byte index r*COLS + c from the MSB.
    // Column-major output places it at byte index c*ROWS + r.
    function automatic logic [OUT_W-1:0] transpose(input logic [OUT_W-1:0] w);
        logic [OUT_W-1:0] t;
        t = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                t[OUT_W-1-8*(c*ROWS+r) -: 8] = w[OUT_W-1-8*(r*COLS+c) -: 8];
            end
        end
        return t;
    endfunction

    assign in_ready   = ~clear & ((beat_cnt != LAST) | ~out_valid | out_ready);
    assign accept     = in_valid & in_ready;
    assign final_beat = (beat_cnt == LAST);

    // When NBEATS == 1, beat 0 is also the final beat. In that case the
    // live mc_mode input decides the mode, not the latched copy.
    assign eff_mode = (beat_cnt == '0) ? mc_mode : mode_latched;

    // Overlay the beat currently arriving onto its slot. On the final
    // beat this gives the complete word without waiting for the buffer.
    always_comb begin
        row_word = asm_buf;
        for (int k = 0; k < NBEATS; k++) begin
            if (beat_cnt == CNT_W'(k)) begin
                row_word[OUT_W-1-k*BEAT_W -: BEAT_W] = in_lanes;
            end
        end
        packed_word = eff_mode ? transpose(row_word) : row_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt     <= '0;
            mode_latched <= 1'b0;
        end else if (clear) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= final_beat ? '0 : beat_cnt + 1'b1;
            if (beat_cnt == '0) begin
                mode_latched <= mc_mode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_buf <= '0;
        end else if (accept) begin
            for (int k = 0; k < NBEATS; k++) begin
                if (beat_cnt == CNT_W'(k)) begin
                    asm_buf[OUT_W-1-k*BEAT_W -: BEAT_W] <= in_lanes;
                end
            end
        end
    end

    // A word that completes on the same edge it is consumed replaces the
    // old word, so the output stays valid with no idle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mode  <= 1'b0;
        end else if (accept && final_beat) begin
            out_valid <= 1'b1;
            out_data  <= packed_word;
            out_mode  <= eff_mode;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_packing_buffer.sv
// tb_packing_buffer
//
// Directed bench for packing_buffer at the default parameters
// (LANE_W=32, NLANES=2, NBEATS=2, 128-bit output word).
module tb_packing_buffer;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_lanes;
    logic         mc_mode;
    logic         clear;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_mode;

    int checks;
    int errors;

    localparam logic [63:0]  A0 = 64'h01020304_05060708;
    localparam logic [63:0]  A1 = 64'h090a0b0c_0d0e0f10;
    localparam logic [127:0] A_ROW = 128'h0102030405060708090a0b0c0d0e0f10;
    localparam logic [127:0] A_MC  = 128'h0105090d02060a0e03070b0f04080c10;
    localparam logic [63:0]  B0 = 64'h11111111_22222222;
    localparam logic [63:0]  B1 = 64'h33333333_44444444;
    localparam logic [127:0] B_ROW = 128'h11111111222222223333333344444444;
    localparam logic [63:0]  C0 = 64'ha0a1a2a3_a4a5a6a7;
    localparam logic [63:0]  C1 = 64'hb0b1b2b3_b4b5b6b7;
    localparam logic [127:0] C_ROW = 128'ha0a1a2a3a4a5a6a7b0b1b2b3b4b5b6b7;
    localparam logic [63:0]  JUNK = 64'hdeadbeef_cafebabe;

    packing_buffer #(
        .LANE_W(32),
        .NLANES(2),
        .NBEATS(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_lanes (in_lanes),
        .mc_mode  (mc_mode),
        .clear    (clear),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_mode (out_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_lanes  = '0;
        mc_mode   = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_out_mode", 128'(out_mode), 128'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        tick();

        // 1. Row mode
        in_valid = 1'b1; in_lanes = A0; mc_mode = 1'b0;
        check("t1_in_ready_b0", 128'(in_ready), 128'd1);
        tick();
        check("t1_valid_after_b0", 128'(out_valid), 128'd0);
        in_lanes = A1;
        tick();
        check("t1_valid", 128'(out_valid), 128'd1);
        check("t1_data", out_data, A_ROW);
        check("t1_mode", 128'(out_mode), 128'd0);

        // 2. MixColumns mode; word 1 is consumed while beat 0 is accepted
        in_lanes = A0; mc_mode = 1'b1;
        tick();
        check("t2_valid_after_b0", 128'(out_valid), 128'd0);
        in_lanes = A1; mc_mode = 1'b0;
        tick();
        check("t2_valid", 128'(out_valid), 128'd1);
        check("t2_data", out_data, A_MC);
        check("t2_mode", 128'(out_mode), 128'd1);
        in_valid = 1'b0;
        tick();
        check("t2_consumed", 128'(out_valid), 128'd0);

        // 3. Backpressure with zero-bubble completion
        out_ready = 1'b0;
        in_valid = 1'b1; in_lanes = A0; mc_mode = 1'b0;
        tick();
        in_lanes = A1;
        tick();
        check("t3_a_valid", 128'(out_valid), 128'd1);
        check("t3_a_data", out_data, A_ROW);
        in_lanes = B0;
        check("t3_b0_ready", 128'(in_ready), 128'd1);
        tick();
        in_lanes = B1;
        check("t3_b1_stall", 128'(in_ready), 128'd0);
        tick();
        check("t3_a_held_valid", 128'(out_valid), 128'd1);
        check("t3_a_held_data", out_data, A_ROW);
        check("t3_b1_still_stall", 128'(in_ready), 128'd0);
        out_ready = 1'b1;
        #1;
        check("t3_b1_ready", 128'(in_ready), 128'd1);
        tick();
        check("t3_b_valid", 128'(out_valid), 128'd1);
        check("t3_b_data", out_data, B_ROW);
        in_valid = 1'b0;
        tick();
        check("t3_b_consumed", 128'(out_valid), 128'd0);

        // 4. Mode change on beat 1 is ignored
        in_valid = 1'b1; in_lanes = A0; mc_mode = 1'b1;
        tick();
        in_lanes = A1; mc_mode = 1'b0;
        tick();
        check("t4_data", out_data, A_MC);
        check("t4_mode", 128'(out_mode), 128'd1);

        // 5. Clear drops the partial word and the beat presented with it
        in_lanes = B0; mc_mode = 1'b0;
        tick();
        clear = 1'b1; in_lanes = JUNK;
        #1;
        check("t5_clear_ready", 128'(in_ready), 128'd0);
        tick();
        check("t5_no_word", 128'(out_valid), 128'd0);
        clear = 1'b0; in_lanes = C0;
        tick();
        check("t5_valid_after_c0", 128'(out_valid), 128'd0);
        in_lanes = C1;
        tick();
        check("t5_valid", 128'(out_valid), 128'd1);
        check("t5_data", out_data, C_ROW);
        in_valid = 1'b0;
        tick();

        // 6. Asynchronous reset with a held word and one beat buffered
        out_ready = 1'b0;
        in_valid = 1'b1; in_lanes = A0; mc_mode = 1'b1;
        tick();
        in_lanes = A1;
        tick();
        in_lanes = B0; mc_mode = 1'b0;
        tick();
        check("t6_held_valid", 128'(out_valid), 128'd1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 128'(out_valid), 128'd0);
        check("t6_rst_data", out_data, 128'd0);
        check("t6_rst_mode", 128'(out_mode), 128'd0);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1; in_lanes = C0; mc_mode = 1'b0;
        tick();
        check("t6_valid_after_c0", 128'(out_valid), 128'd0);
        in_lanes = C1;
        tick();
        check("t6_valid", 128'(out_valid), 128'd1);
        check("t6_data", out_data, C_ROW);
        check("t6_mode", 128'(out_mode), 128'd0);
        in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/packing_buffer.md
Name: packing_buffer

Overview:
- Sequential, parametrised successor to the combinational ALU-result packer.
- Collects NLANES ALU lane results per beat over NBEATS beats into one OUT_W-bit cipher state word, with valid/ready handshakes on both sides.
- Optional MixColumns mode emits the byte matrix transposed (column-major).
- Sits between the vector ALU writeback and the state register file / MixColumns unit.

Parameters:
LANE_W, 32, width of one ALU lane result in bits; must be a multiple of 8
NLANES, 2, lanes delivered per input beat
NBEATS, 2, beats per packed word; must be >= 1; OUT_W = LANE_W*NLANES*NBEATS (derived, 128 at defaults)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_lanes  in  LANE_W*NLANES  lane results; lane 0 in MSBs
mc_mode  in  1  1 = MixColumns (transposed) packing; sampled on beat 0 only
clear  in  1  synchronous abort of a partially assembled word
out_valid  out  1  packed word available
out_ready  in  1  consumer accepts packed word
out_data  out  OUT_W  packed word
out_mode  out  1  mode the presented word was packed in

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_mode=0, beat counter=0, assembly buffer=0, latched mode=0; in_ready=1 after release.
- Accept = in_valid & in_ready at rising edge. Accepted beat k is written to the assembly buffer slot k; beat k lane j occupies global lane index k*NLANES+j. Global lane 0 is in the MSBs of the row-major word.
- Beat counter: 0..NBEATS-1. It increments on accept and wraps to 0 after the last beat.
- Mode latch: mc_mode is latched on acceptance of beat 0. Changes on later beats of the same word are ignored.
- Word completion: on the edge accepting beat NBEATS-1, the output register loads the finished word. out_valid=1 and out_mode=latched mode from that edge, i.e. 1 cycle after the final beat. With NBEATS=1, every beat is a final beat.
- Row mode (mode=0): out_data = concatenation of global lanes 0..L-1, MSB first, where L = NLANES*NBEATS.
- MC mode (mode=1): treat the word as an L-row x (LANE_W/8)-column byte matrix, with row r = global lane r and byte 0 in the MSB. out_data emits it column-major: column 0 bytes of rows 0..L-1, then column 1, and so on, MSB first.
- Output handshake: out_valid stays high and out_data/out_mode stay stable until out_valid & out_ready. On that edge out_valid drops, unless a new word completes on the same edge, in which case it stays 1 with the new data.
- in_ready rule: in_ready = ~clear & ((beat counter != NBEATS-1) | ~out_valid | out_ready).
  - Non-final beats of the next word are accepted while a finished word is still held.
  - Only the final beat stalls under backpressure; it completes in the same cycle out_ready rises (zero bubble).
- clear: when high, the beat counter returns to 0, the partial word is discarded and in_ready=0. out_valid, out_data and out_mode are unaffected. clear with in_valid: the beat is not accepted.
- Reset mid-word or mid-hold: everything returns to reset values immediately; the partial word and any held output are lost.

Test Plan:
1. Row mode, NBEATS=2, out_ready=1: beats 0x01020304_05060708 then 0x090a0b0c_0d0e0f10, mc_mode=0 -> one cycle after beat 2, out_valid=1, out_data=0x0102030405060708090a0b0c0d0e0f10, out_mode=0.
2. MC mode: same beats, mc_mode=1 on beat 0 -> out_data=0x0105090d02060a0e03070b0f04080c10, out_mode=1.
3. Backpressure: out_ready=0 with word A held.
   - Next word's beat 0 is accepted (in_ready=1); beat 1 sees in_ready=0 and holds.
   - Raise out_ready -> A consumed and beat 1 accepted on the same edge; next cycle out_valid=1 with word B, no idle cycle.
4. Mode change mid-word: mc_mode=1 on beat 0, mc_mode=0 on beat 1 -> transposed output, out_mode=1.
5. Clear: accept beat 0, pulse clear with in_valid=1 -> that beat is dropped, in_ready=0 during clear. Then two fresh beats -> word contains only the fresh beats.
6. Async reset with out_valid=1 and one beat buffered -> out_valid=0 and out_data=0 immediately. After release, a full two-beat sequence packs correctly from slot 0.
